rib_arbiter: RTL

//  Read/write bus arbiter and address decoder between bus masters (core data port, core fetch port, JTAG,

---
 rtl/rib_arbiter_pkg.sv | 24 ++
 rtl/rib_arbiter_prio_enc.sv | 27 ++
 rtl/rib_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB bus arbiter.
//   rib_state_e   : arbiter FSM states (idle / transfer in progress)
//   RibSlvSelW    : width of the slave-select field in the address
//   RibSlvSelLsb  : bit position of the slave-select field
//   RIB_ERR_DATA  : read data returned on decode error or timeout
package rib_arbiter_pkg;

  typedef enum logic [0:0] {
    RIB_IDLE = 1'b0,
    RIB_XFER = 1'b1
  } rib_state_e;

  localparam int          RibSlvSelW   = 4;
  localparam int          RibSlvSelLsb = 28;
  localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

  // Mask that clears the slave-select field from a bus address.
  function automatic logic [31:0] rib_local_addr(input logic [31:0] addr);
    logic [31:0] mask;
    mask = (32'h1 << RibSlvSelLsb) - 32'h1;
    return addr & mask;
  endfunction

endpackage

// File: rtl/rib_arbiter_prio_enc.sv
// Lowest-index-wins priority encoder used for master arbitration.
// Ports:
//   req_i  : request vector, bit 0 has the highest priority
//   idx_o  : index of the lowest set bit (0 when no bit is set)
//   any_o  : at least one request bit is set
module rib_arbiter_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rib_arbiter.sv
// Read/write bus arbiter and address decoder between the bus masters (core
// data, core fetch, JTAG, debug loader) and the memory-mapped slaves.
// A fixed-priority grant is taken in IDLE and held for the whole transfer;
// the address top nibble selects the slave.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   m_req_i      : per-master request, held until m_ready_o
//   m_we_i       : per-master write enable
//   m_addr_i     : per-master address
//   m_data_i     : per-master write data
//   m_data_o     : shared read data, valid with m_ready_o, else 0
//   m_ready_o    : one-hot completion pulse to the granted master
//   s_req_o      : one-hot slave request
//   s_we_o       : slave write enable
//   s_addr_o     : slave address with the select nibble cleared
//   s_data_o     : slave write data
//   s_data_i     : per-slave read data
//   s_ready_i    : per-slave completion
//   hold_flag_o  : core stall request
//   err_o        : one-cycle pulse on decode error or timeout
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int          NUM_MASTERS = 4,
  parameter int          NUM_SLAVES  = 8,
  parameter int          FETCH_MST   = 1,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = RIB_ERR_DATA
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS-1:0]      m_req_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_data_i,
  output logic [31:0]                 m_data_o,
  output logic [NUM_MASTERS-1:0]      m_ready_o,
  output logic [NUM_SLAVES-1:0]       s_req_o,
  output logic                        s_we_o,
  output logic [31:0]                 s_addr_o,
  output logic [31:0]                 s_data_o,
  input  logic [NUM_SLAVES-1:0][31:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]       s_ready_i,
  output logic                        hold_flag_o,
  output logic                        err_o
);

  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // Timer value during the last XFER cycle before a timeout completion.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [NUM_MASTERS-1:0] FETCH_MASK = NUM_MASTERS'(1) << FETCH_MST;

  rib_state_e            state_q;
  logic [MIW-1:0]        grant_q;
  logic [RibSlvSelW-1:0] slave_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;

  logic                  enc_any;
  logic [MIW-1:0]        enc_idx;
  logic [RibSlvSelW-1:0] req_slv;

  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;

  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  slave_valid;

  logic                  in_xfer;
  logic                  ok_done;
  logic                  dec_err;
  logic                  tmo;
  logic                  done;

  rib_arbiter_prio_enc #(
    .N  (NUM_MASTERS),
    .IW (MIW)
  ) u_prio_enc (
    .req_i (m_req_i),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Slave select of the master that would win arbitration this cycle.
  always_comb begin
    req_slv = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (enc_idx == MIW'(k)) begin
        req_slv = m_addr_i[k][RibSlvSelLsb +: RibSlvSelW];
      end
    end
  end

  // Master-side mux driven by the latched grant.
  always_comb begin
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q == MIW'(k)) begin
        cur_we    = m_we_i[k];
        cur_addr  = m_addr_i[k];
        cur_wdata = m_data_i[k];
      end
    end
  end

  // Slave-side mux driven by the latched slave select; ready from any other
  // slave never reaches sel_ready.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slave_q == RibSlvSelW'(k)) begin
        sel_ready = s_ready_i[k];
        sel_rdata = s_data_i[k];
      end
    end
  end

  assign slave_valid = (int'(slave_q) < NUM_SLAVES);

  // Completion classification. A ready arriving in the last allowed cycle
  // still wins over the timeout.
  always_comb begin
    in_xfer = (state_q == RIB_XFER);
    ok_done = in_xfer && slave_valid && sel_ready;
    dec_err = in_xfer && !slave_valid;
    tmo     = in_xfer && slave_valid && !sel_ready && (timer_q == TMO_LAST);
    done    = ok_done || dec_err || tmo;
    timer_d = timer_q + TW'(1);
  end

  always_comb begin
    m_ready_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      m_ready_o[k] = done && (grant_q == MIW'(k));
    end

    if (ok_done) begin
      m_data_o = sel_rdata;
    end else if (dec_err || tmo) begin
      m_data_o = ERR_DATA;
    end else begin
      m_data_o = '0;
    end

    err_o = dec_err || tmo;

    s_req_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_req_o[k] = in_xfer && (slave_q == RibSlvSelW'(k));
    end

    s_we_o   = in_xfer && cur_we;
    s_addr_o = in_xfer ? rib_local_addr(cur_addr) : '0;
    s_data_o = in_xfer ? cur_wdata : '0;
  end

  // The core stalls while a non-fetch master owns the bus or is asking for it.
  always_comb begin
    hold_flag_o = (in_xfer && (grant_q != MIW'(FETCH_MST)))
                  || (|(m_req_i & ~FETCH_MASK));
  end

  // Arbitration FSM: grant is only re-evaluated in IDLE, so every transfer
  // is followed by at least one IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RIB_IDLE;
      grant_q <= '0;
      slave_q <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        RIB_IDLE: begin
          if (enc_any) begin
            grant_q <= enc_idx;
            slave_q <= req_slv;
            timer_q <= '0;
            state_q <= RIB_XFER;
          end
        end
        RIB_XFER: begin
          if (done) begin
            state_q <= RIB_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          state_q <= RIB_IDLE;
        end
      endcase
    end
  end

endmodule
